// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: serialises CPU loads/stores through IDLE/BUSY/RESP.
// Define DMEM_ALIGN_CHECK_EN to add the addr_err output and suppress misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_dataout,
  output logic [31:0] d_datain,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        addr_err,
`endif
  output logic        ready
);

  localparam int AW = $clog2(DEPTH);
  // Counter value on the final BUSY cycle; unused when LATENCY is 1.
  localparam logic [3:0] BUSY_LAST = 4'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            op_write_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic            mis_reg;
  logic            ready_reg;
  logic            addr_err_reg;
  logic [31:0]     d_datain_reg;
  logic [31:0]     mem [DEPTH];

  logic            req_valid;
  logic            req_mis;
  logic            accept;
  logic            from_idle;
  logic            eff_write;
  logic            eff_mis;
  logic [AW-1:0]   eff_idx;
  logic [31:0]     eff_wdata;
  logic            enter_resp;
  logic            mem_we;
  logic            load_en;
  logic            unused_addr;

  assign req_valid = mem_read | mem_write;
`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = (d_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif
  assign unused_addr = ^{d_addr[31:AW+2], d_addr[1:0]};

  assign from_idle = (state_reg == IDLE);
  assign accept    = from_idle & req_valid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          cnt_next   = 4'd0;
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == BUSY_LAST) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= 32'd0;
      mis_reg      <= 1'b0;
    end else if (accept) begin
      op_write_reg <= mem_write;
      idx_reg      <= d_addr[AW+1:2];
      wdata_reg    <= d_dataout;
      mis_reg      <= req_mis;
    end
  end

  // With LATENCY=1 the RESP entry coincides with acceptance, so use live inputs then.
  assign eff_write = from_idle ? mem_write       : op_write_reg;
  assign eff_mis   = from_idle ? req_mis         : mis_reg;
  assign eff_idx   = from_idle ? d_addr[AW+1:2]  : idx_reg;
  assign eff_wdata = from_idle ? d_dataout       : wdata_reg;

  assign enter_resp = ~reset & (state_next == RESP) & (state_reg != RESP);
  assign mem_we     = enter_resp & eff_write & ~eff_mis;
  assign load_en    = enter_resp & ~eff_write & ~eff_mis;

  // Memory contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[eff_idx] <= eff_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_datain_reg <= 32'd0;
      ready_reg    <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      if (load_en) begin
        d_datain_reg <= mem[eff_idx];
      end
      ready_reg    <= enter_resp;
      addr_err_reg <= enter_resp & eff_mis;
    end
  end

  assign d_datain = d_datain_reg;
  assign ready    = ready_reg;
`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_err = addr_err_reg;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against an array-based memory model.
module tb_data_mem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clock;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] d_addr;
  logic [31:0] d_dataout;
  logic [31:0] d_datain;
  logic        ready;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        addr_err;
`endif

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_datain  (d_datain),
`ifdef DMEM_ALIGN_CHECK_EN
    .addr_err  (addr_err),
`endif
    .ready     (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] mem_model [DEPTH];
  logic [31:0] dout_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the ready pulse has ended.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input string tag);
    int   cycles;
    logic got;
    logic mis;
    int   idx;
    idx = int'((addr / 4) % DEPTH);
    mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr % 4) != 0;
`endif
    mem_read  = rd;
    mem_write = wr;
    d_addr    = addr;
    d_dataout = data;
    @(posedge clock);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (ready) begin
        got       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end else begin
        // Noise while busy must be ignored by the responder.
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        d_addr    = $urandom;
        d_dataout = $urandom;
      end
    end
    if (!got) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      chk({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      if (wr && !mis) mem_model[idx] = data;
      else if (rd && !wr && !mis) dout_model = mem_model[idx];
      chk({tag, ".latency"}, 32'(cycles), 32'(LATENCY));
      chk({tag, ".d_datain"}, d_datain, dout_model);
`ifdef DMEM_ALIGN_CHECK_EN
      chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, mis});
`endif
      @(negedge clock);
      chk({tag, ".ready_drop"}, {31'd0, ready}, 32'd0);
      chk({tag, ".d_datain_hold"}, d_datain, dout_model);
`ifdef DMEM_ALIGN_CHECK_EN
      chk({tag, ".addr_err_drop"}, {31'd0, addr_err}, 32'd0);
`endif
    end
    $display("txn %-10s rd=%0d wr=%0d addr=%h wdata=%h d_datain=%h cycles=%0d",
             tag, rd, wr, addr, data, d_datain, cycles);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] lo;
    int          k;
    int          kind;

    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    d_addr = 32'h4; d_dataout = 32'h0;
    dout_model = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.d_datain", d_datain, 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("reset.addr_err", {31'd0, addr_err}, 32'd0);
`endif
    reset = 1'b0; mem_read = 1'b0;
    @(negedge clock);
    chk("reset.no_accept", {31'd0, ready}, 32'd0);

    // Directed scenarios.
    access(1'b0, 1'b1, 32'h0000_0004, 32'h0000_00ab, "st4");
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0,         "ld4");
    chk("ld4.value", d_datain, 32'h0000_00ab);
    access(1'b0, 1'b1, 32'h0000_0008, 32'h0000_3c00, "st8");
    chk("st8.dout_unchanged", d_datain, 32'h0000_00ab);
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0,         "ld4b");
    access(1'b1, 1'b0, 32'h0000_0008, 32'h0,         "ld8");
    chk("ld8.value", d_datain, 32'h0000_3c00);
    access(1'b0, 1'b1, 32'h0000_0400, 32'hdead_beef, "st400");
    access(1'b1, 1'b0, 32'h0000_0000, 32'h0,         "ld0wrap");
    chk("ld0wrap.value", d_datain, 32'hdead_beef);

    // Reset in the BUSY cycle of a store aborts it.
    access(1'b0, 1'b1, 32'h0000_000c, 32'h1111_2222, "pre_c");
    mem_write = 1'b1; d_addr = 32'h0000_000c; d_dataout = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1; mem_write = 1'b0;
    chk("abort.busy_ready", {31'd0, ready}, 32'd0);
    @(negedge clock);
    chk("abort.ready", {31'd0, ready}, 32'd0);
    chk("abort.d_datain", d_datain, 32'd0);
    reset = 1'b0;
    dout_model = 32'd0;
    @(negedge clock);
    chk("abort.idle_ready", {31'd0, ready}, 32'd0);
    chk("abort.d_datain_hold", d_datain, 32'd0);
    access(1'b1, 1'b0, 32'h0000_000c, 32'h0,         "ld_c");
    chk("ld_c.value", d_datain, 32'h1111_2222);

    // Both read and write asserted is a store.
    access(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0055, "both10");
    chk("both10.dout_unchanged", d_datain, 32'h1111_2222);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0,         "ld10");
    chk("ld10.value", d_datain, 32'h0000_0055);

`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b0, 1'b1, 32'h0000_0005, 32'hffff_ffff, "mis5");
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0,         "ld4c");
    chk("ld4c.value", d_datain, 32'h0000_00ab);
`else
    access(1'b1, 1'b0, 32'h0000_0006, 32'h0,         "ld6");
    chk("ld6.value", d_datain, 32'h0000_00ab);
`endif

    // Prefill words 0..15 through aliased, aligned addresses.
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hffff_fc00) | 32'(i * 4);
      access(1'b0, 1'b1, a, $urandom, "fill");
    end

    // Random mix of loads, stores and read+write over those words.
    for (int i = 0; i < 60; i++) begin
      k    = int'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 2));
`ifdef DMEM_ALIGN_CHECK_EN
      lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
`else
      lo = 32'($urandom_range(0, 3));
`endif
      a = ($urandom & 32'hffff_fc00) | 32'(k * 4) | lo;
      access(kind != 1, kind != 0, a, $urandom, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
